tally_score_ctrl: RTL and testbench

- Sequencing controller for the two-digit tally display datapath.
- Accepts already-debounced increment, decrement and clear switch levels and converts them to single-step events: edge detect, fixed priority, optional hold-to-repeat.
- Maintains a 0..99 BCD score whose digits feed the two Binary_To_7Segment decoders directly (tens to display 1, ones to display 2).

---
 rtl/tally_score_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tally_score_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tally_score_ctrl.sv
// Tally score controller: edge-detected Inc/Dec/Clr keys step a two-digit BCD score, 1-cycle latency, no backpressure.
// Hold-to-repeat (HELD->REPEAT auto-stepping) is built only when TALLY_AUTO_REPEAT_EN is defined.
module tally_score_ctrl #(
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Inc,
  input  logic       i_Dec,
  input  logic       i_Clr,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Wrap,
  output logic       o_Held
);

`ifdef TALLY_AUTO_REPEAT_EN
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW      = $clog2(MAX_CNT);
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_e;
  logic [TW-1:0] timer_q, timer_d;
`else
  typedef enum logic [0:0] {S_IDLE, S_HELD} state_e;
`endif

  // A timer shorter than 2 cycles cannot separate the first step from the next.
  if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_repeat_param
  end

  state_e     state_q, state_d;
  logic       inc_prev_q, dec_prev_q, clr_prev_q;
  logic       key_q, key_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic       wrap_q, wrap_d;
  logic       inc_ev, dec_ev, clr_ev, key_lvl;
  logic       step, step_up, clr;

  assign inc_ev  = i_Inc & ~inc_prev_q;
  assign dec_ev  = i_Dec & ~dec_prev_q;
  assign clr_ev  = i_Clr & ~clr_prev_q;
  assign key_lvl = key_q ? i_Inc : i_Dec;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    step    = 1'b0;
    step_up = key_q;
    clr     = 1'b0;
`ifdef TALLY_AUTO_REPEAT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (clr_ev) begin
          clr = 1'b1;
        end else if (inc_ev || dec_ev) begin
          step    = 1'b1;
          step_up = inc_ev;
          key_d   = inc_ev;
          state_d = S_HELD;
`ifdef TALLY_AUTO_REPEAT_EN
          timer_d = '0;
`endif
        end
      end
      S_HELD: begin
        if (clr_ev) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end else if (!key_lvl) begin
          state_d = S_IDLE;
`ifdef TALLY_AUTO_REPEAT_EN
        end else if (timer_q == TW'(REPEAT_DELAY - 1)) begin
          step    = 1'b1;
          state_d = S_REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
`endif
        end
`ifdef TALLY_AUTO_REPEAT_EN
        if (state_d != S_HELD) timer_d = '0;
`endif
      end
`ifdef TALLY_AUTO_REPEAT_EN
      S_REPEAT: begin
        // Release and Clr both take precedence over a step falling due this cycle.
        if (clr_ev) begin
          clr     = 1'b1;
          state_d = S_IDLE;
          timer_d = '0;
        end else if (!key_lvl) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(REPEAT_RATE - 1)) begin
          step    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_Held = (state_q != S_IDLE);
    o_Tens = tens_q;
    o_Ones = ones_q;
    o_Wrap = wrap_q;
    tens_d = tens_q;
    ones_d = ones_q;
    wrap_d = 1'b0;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (step && step_up) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        if (tens_q == 4'd9) begin
          tens_d = 4'd0;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (step) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        if (tens_q == 4'd0) begin
          tens_d = 4'd9;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q - 4'd1;
        end
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // Previous samples reset high so a key held through reset release is not an event.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      inc_prev_q <= 1'b1;
      dec_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
      key_q      <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      wrap_q     <= 1'b0;
    end else begin
      inc_prev_q <= i_Inc;
      dec_prev_q <= i_Dec;
      clr_prev_q <= i_Clr;
      key_q      <= key_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef TALLY_AUTO_REPEAT_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) timer_q <= '0;
    else          timer_q <= timer_d;
  end
`endif

endmodule

// File: tb/tb_tally_score_ctrl.sv
// Bench for tally_score_ctrl (REPEAT_DELAY=8, REPEAT_RATE=4): integer-score reference model feeds a scoreboard
// checked every cycle; repeat expectations follow TALLY_AUTO_REPEAT_EN as the RTL is built.
module tb_tally_score_ctrl;
  localparam int D = 8;
  localparam int R = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L, i_Inc, i_Dec, i_Clr;
  logic [3:0] o_Tens, o_Ones;
  logic       o_Wrap, o_Held;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb[$];

  int m_score = 0;
  int m_n = 0;
  bit m_act = 0, m_key = 0, m_wrap = 0;
  bit p_inc = 1, p_dec = 1, p_clr = 1;

  tally_score_ctrl #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_Inc  (i_Inc),
    .i_Dec  (i_Dec),
    .i_Clr  (i_Clr),
    .o_Tens (o_Tens),
    .o_Ones (o_Ones),
    .o_Wrap (o_Wrap),
    .o_Held (o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic do_step(input bit up);
    m_wrap  = up ? (m_score == 99) : (m_score == 0);
    m_score = up ? (m_score + 1) % 100 : (m_score + 99) % 100;
  endtask

  // Reference model: score as an integer, hold tracked as cycles since the press.
  always @(posedge i_Clk) begin : model
    bit ie, de, ce, lvl;
    m_wrap = 0;
    if (!i_Rst_L) begin
      m_score = 0; m_act = 0; m_n = 0;
      p_inc = 1; p_dec = 1; p_clr = 1;
    end else begin
      ie = i_Inc && !p_inc;
      de = i_Dec && !p_dec;
      ce = i_Clr && !p_clr;
      if (!m_act) begin
        if (ce) m_score = 0;
        else if (ie || de) begin
          m_key = ie;
          do_step(ie);
          m_act = 1;
          m_n = 0;
        end
      end else begin
        lvl = m_key ? i_Inc : i_Dec;
        if (ce) begin
          m_score = 0;
          m_act = 0;
        end else if (!lvl) begin
          m_act = 0;
        end else begin
          m_n++;
`ifdef TALLY_AUTO_REPEAT_EN
          if (m_n == D || (m_n > D && (m_n - D) % R == 0)) do_step(m_key);
`endif
        end
      end
      p_inc = i_Inc; p_dec = i_Dec; p_clr = i_Clr;
    end
    sb.push_back({4'(m_score / 10), 4'(m_score % 10), m_wrap, m_act});
  end

  always @(negedge i_Clk) begin : monitor
    logic [9:0] exp_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if ({o_Tens, o_Ones, o_Wrap, o_Held} !== exp_v) begin
        errors++;
        $display("FAIL scoreboard @%0t: got tens=%0d ones=%0d wrap=%0b held=%0b, want tens=%0d ones=%0d wrap=%0b held=%0b",
                 $time, o_Tens, o_Ones, o_Wrap, o_Held, exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge i_Clk);
      #1;
    end
  endtask

  // k: 0 = Inc, 1 = Dec, 2 = Clr
  task automatic press(input int k, input int n);
    if (k == 0) i_Inc = 1'b1; else if (k == 1) i_Dec = 1'b1; else i_Clr = 1'b1;
    tick(n);
    i_Inc = 1'b0; i_Dec = 1'b0; i_Clr = 1'b0;
    tick(2);
  endtask

  task automatic goto_val(input int v);
    press(2, 1);
    for (int i = 0; i < v; i++) press(0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_Rst_L = 1'b0; i_Inc = 1'b1; i_Dec = 1'b0; i_Clr = 1'b0;
    tick(3);
    i_Rst_L = 1'b1;
    tick(5);
    i_Inc = 1'b0;
    tick(2);
    press(0, 3);

    // wraps and carry
    press(2, 1);
    press(1, 2);
    press(0, 2);
    for (int i = 0; i < 9; i++) press(0, 1);
    press(0, 1);

    // hold-to-repeat, release coinciding with a rate expiry
    press(2, 1);
    i_Inc = 1'b1;
    tick(20);
    i_Inc = 1'b0;
    tick(3);

    // priority
    goto_val(42);
    i_Clr = 1'b1; i_Inc = 1'b1; i_Dec = 1'b1;
    tick(2);
    i_Clr = 1'b0; i_Inc = 1'b0; i_Dec = 1'b0;
    tick(2);
    goto_val(42);
    i_Inc = 1'b1; i_Dec = 1'b1;
    tick(3);
    i_Dec = 1'b0;
    tick(2);
    i_Inc = 1'b0;
    tick(2);

    // clear mid-repeat with Dec still held
    goto_val(50);
    i_Dec = 1'b1;
    tick(15);
    i_Clr = 1'b1;
    tick(1);
    i_Clr = 1'b0;
    tick(10);
    i_Dec = 1'b0;
    tick(2);
    press(1, 1);

    // long hold, then re-press
    press(2, 1);
    i_Inc = 1'b1;
    tick(100);
    i_Inc = 1'b0;
    tick(2);
    press(0, 1);

    // reset mid-hold must clear outputs without waiting for a clock
    i_Inc = 1'b1;
    tick(5);
    i_Rst_L = 1'b0;
    #1;
    checks++;
    if ({o_Tens, o_Ones, o_Wrap, o_Held} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got tens=%0d ones=%0d wrap=%0b held=%0b, want all zero",
               o_Tens, o_Ones, o_Wrap, o_Held);
    end
    tick(2);
    i_Rst_L = 1'b1;
    tick(3);
    i_Inc = 1'b0;
    tick(2);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) i_Inc = ~i_Inc;
      if ($urandom_range(0, 11) == 0) i_Dec = ~i_Dec;
      if ($urandom_range(0, 19) == 0) i_Clr = ~i_Clr;
      i_Rst_L = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    i_Rst_L = 1'b1; i_Inc = 1'b0; i_Dec = 1'b0; i_Clr = 1'b0;
    tick(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
